// File: rtl/slv_guard_pkg.sv
// slv_guard_pkg
//   Shared types for the slave-guard tracker: FSM state encoding, fault cause
//   encoding, per-tracker flag bundle and the outstanding-count width helper.
package slv_guard_pkg;

  typedef enum logic [1:0] {
    MONITOR = 2'd0,
    FAULT   = 2'd1,
    RESET   = 2'd2,
    CLEAR   = 2'd3
  } guard_state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'd0,
    CAUSE_TIMEOUT  = 2'd1,
    CAUSE_OVERFLOW = 2'd2,
    CAUSE_SPURIOUS = 2'd3
  } fault_cause_e;

  typedef struct packed {
    logic timeout;
    logic overflow;
    logic spurious;
  } trk_flags_t;

  function automatic int unsigned cnt_width(input int unsigned max_txns);
    return $clog2(max_txns + 1);
  endfunction

  localparam int unsigned MaxTxnsPerId = 4;
  localparam int unsigned CntWidth     = $clog2(MaxTxnsPerId + 1);

  // Within one tracker a timeout outranks an overflow; overflow and spurious
  // cannot coincide because they need issue-only and retire-only respectively.
  function automatic fault_cause_e flags_to_cause(input trk_flags_t f);
    if (f.timeout)       return CAUSE_TIMEOUT;
    else if (f.overflow) return CAUSE_OVERFLOW;
    else if (f.spurious) return CAUSE_SPURIOUS;
    else                 return CAUSE_NONE;
  endfunction

endpackage

// File: rtl/slv_guard_id_tracker.sv
// slv_guard_id_tracker
//   Outstanding-transaction state for one AXI ID in one direction.
//   Holds the outstanding count, the age timer and registered fault flags.
// Ports
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   ena_i           timeouts armed; timer held at 0 while low
//   tick_i          prescaler tick, timer advances on it
//   clear_i         synchronous zeroing of count, timer and flags
//   issue_i         AW/AR handshake addressed to this ID
//   retire_i        B / R-last handshake addressed to this ID
//   budget_i        timeout budget in ticks, 0 disables
//   full_o          count at the depth limit (only when StallEn)
//   flags_o         registered timeout / overflow / spurious flags
module slv_guard_id_tracker
  import slv_guard_pkg::*;
#(
  parameter int unsigned MaxTxnsPerId = 4,
  parameter int unsigned CounterWidth = 16,
  parameter bit          StallEn      = 1'b0
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    ena_i,
  input  logic                    tick_i,
  input  logic                    clear_i,
  input  logic                    issue_i,
  input  logic                    retire_i,
  input  logic [CounterWidth-1:0] budget_i,
  output logic                    full_o,
  output trk_flags_t              flags_o
);

  // The package width covers the default depth; other depths size themselves.
  localparam int unsigned CntW = (MaxTxnsPerId == slv_guard_pkg::MaxTxnsPerId) ?
                                 CntWidth : cnt_width(MaxTxnsPerId);
  localparam logic [CntW-1:0] CntMax = CntW'(MaxTxnsPerId);

  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [CounterWidth-1:0] timer_q, timer_d, timer_adv;
  logic                    timeout_q, timeout_d;
  logic                    overflow_q, overflow_d;
  logic                    spurious_q, spurious_d;
  logic                    busy;

  assign busy = (cnt_q != '0);

  // Age timer: held at 0 when disarmed, saturates at all-ones.
  always_comb begin
    timer_adv = timer_q;
    if (!ena_i) begin
      timer_adv = '0;
    end else if (tick_i && busy && (timer_q != '1)) begin
      timer_adv = timer_q + 1'b1;
    end
  end

  always_comb begin
    cnt_d      = cnt_q;
    timer_d    = timer_adv;
    overflow_d = 1'b0;
    spurious_d = 1'b0;
    timeout_d  = ena_i && busy && (budget_i != '0) && (timer_q >= budget_i);
    if (clear_i) begin
      cnt_d     = '0;
      timer_d   = '0;
      timeout_d = 1'b0;
    end else if (issue_i && retire_i) begin
      timer_d = '0;
    end else if (issue_i) begin
      if (cnt_q == CntMax) begin
        overflow_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
        if (!busy) timer_d = '0;
      end
    end else if (retire_i) begin
      if (!busy) spurious_d = 1'b1;
      else       cnt_d      = cnt_q - 1'b1;
      timer_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q      <= '0;
      timer_q    <= '0;
      timeout_q  <= 1'b0;
      overflow_q <= 1'b0;
      spurious_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      timer_q    <= timer_d;
      timeout_q  <= timeout_d;
      overflow_q <= overflow_d;
      spurious_q <= spurious_d;
    end
  end

  assign full_o           = StallEn && (cnt_q == CntMax);
  assign flags_o.timeout  = timeout_q;
  assign flags_o.overflow = overflow_q;
  assign flags_o.spurious = spurious_q;

endmodule

// File: rtl/slv_guard_tracker.sv
// slv_guard_tracker
//   Per-ID, per-direction AXI outstanding-transaction tracker with timeout,
//   overflow and spurious-response detection, plus a fault / subordinate
//   reset handshake FSM. Observes handshakes only, never touches the datapath.
//   Optional macro SLV_GUARD_STALL_EN drives aw_stall_o / ar_stall_o from the
//   depth limit; without it both are tied 0.
// Ports
//   clk_i, rst_ni                clock, asynchronous active-low reset
//   guard_ena_i                  arm timeouts
//   aw_hs_i/aw_id_i, b_hs_i/b_id_i              write issue / retire
//   ar_hs_i/ar_id_i, r_hs_i/r_last_i/r_id_i     read issue / retire
//   budget_w_i, budget_r_i       timeout budgets in prescaled ticks (0 = off)
//   irq_o, rst_req_o, rst_stat_i fault interrupt and reset handshake
//   fault_id_o, fault_cause_o, fault_rd_o       first captured fault
//   aw_stall_o, ar_stall_o       depth-limit stall hints
module slv_guard_tracker
  import slv_guard_pkg::*;
#(
  parameter int unsigned IdWidth      = 4,
  parameter int unsigned MaxTxnsPerId = 4,
  parameter int unsigned CounterWidth = 16,
  parameter int unsigned PrescalerDiv = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    guard_ena_i,
  input  logic                    aw_hs_i,
  input  logic [IdWidth-1:0]      aw_id_i,
  input  logic                    b_hs_i,
  input  logic [IdWidth-1:0]      b_id_i,
  input  logic                    ar_hs_i,
  input  logic [IdWidth-1:0]      ar_id_i,
  input  logic                    r_hs_i,
  input  logic                    r_last_i,
  input  logic [IdWidth-1:0]      r_id_i,
  input  logic [CounterWidth-1:0] budget_w_i,
  input  logic [CounterWidth-1:0] budget_r_i,
  output logic                    irq_o,
  output logic                    rst_req_o,
  input  logic                    rst_stat_i,
  output logic [IdWidth-1:0]      fault_id_o,
  output logic [1:0]              fault_cause_o,
  output logic                    fault_rd_o,
  output logic                    aw_stall_o,
  output logic                    ar_stall_o
);

  localparam int unsigned NumIds = 1 << IdWidth;
  localparam int unsigned PscW   = (PrescalerDiv > 1) ? $clog2(PrescalerDiv) : 1;
  localparam logic [PscW-1:0] PscLast = PscW'(PrescalerDiv - 1);

`ifdef SLV_GUARD_STALL_EN
  localparam bit StallEn = 1'b1;
`else
  localparam bit StallEn = 1'b0;
`endif

  logic [PscW-1:0]    psc_q;
  logic               tick;
  logic               clear;
  trk_flags_t         flags_w [NumIds];
  trk_flags_t         flags_r [NumIds];
  logic [NumIds-1:0]  full_w, full_r;

  guard_state_e       state_q;
  logic               irq_q, rst_req_q, fault_rd_q;
  logic [IdWidth-1:0] fault_id_q;
  fault_cause_e       fault_cause_q;

  logic               hit;
  logic               hit_rd;
  logic [IdWidth-1:0] hit_id;
  fault_cause_e       hit_cause;

  // Free-running prescaler, only the async reset touches it.
  assign tick = (psc_q == PscLast);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) psc_q <= '0;
    else         psc_q <= tick ? '0 : psc_q + 1'b1;
  end

  assign clear = (state_q == CLEAR);

  for (genvar g = 0; g < NumIds; g++) begin : g_wr
    slv_guard_id_tracker #(
      .MaxTxnsPerId (MaxTxnsPerId),
      .CounterWidth (CounterWidth),
      .StallEn      (StallEn)
    ) u_trk (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .ena_i    (guard_ena_i),
      .tick_i   (tick),
      .clear_i  (clear),
      .issue_i  (aw_hs_i && (aw_id_i == IdWidth'(g))),
      .retire_i (b_hs_i && (b_id_i == IdWidth'(g))),
      .budget_i (budget_w_i),
      .full_o   (full_w[g]),
      .flags_o  (flags_w[g])
    );
  end

  for (genvar g = 0; g < NumIds; g++) begin : g_rd
    slv_guard_id_tracker #(
      .MaxTxnsPerId (MaxTxnsPerId),
      .CounterWidth (CounterWidth),
      .StallEn      (StallEn)
    ) u_trk (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .ena_i    (guard_ena_i),
      .tick_i   (tick),
      .clear_i  (clear),
      .issue_i  (ar_hs_i && (ar_id_i == IdWidth'(g))),
      .retire_i (r_hs_i && r_last_i && (r_id_i == IdWidth'(g))),
      .budget_i (budget_r_i),
      .full_o   (full_r[g]),
      .flags_o  (flags_r[g])
    );
  end

  // Priority: whole write side first, then read side; lowest ID first.
  always_comb begin
    hit       = 1'b0;
    hit_rd    = 1'b0;
    hit_id    = '0;
    hit_cause = CAUSE_NONE;
    for (int unsigned i = 0; i < NumIds; i++) begin
      if (!hit && (|flags_w[i])) begin
        hit       = 1'b1;
        hit_id    = IdWidth'(i);
        hit_cause = flags_to_cause(flags_w[i]);
      end
    end
    for (int unsigned i = 0; i < NumIds; i++) begin
      if (!hit && (|flags_r[i])) begin
        hit       = 1'b1;
        hit_rd    = 1'b1;
        hit_id    = IdWidth'(i);
        hit_cause = flags_to_cause(flags_r[i]);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= MONITOR;
      irq_q         <= 1'b0;
      rst_req_q     <= 1'b0;
      fault_id_q    <= '0;
      fault_cause_q <= CAUSE_NONE;
      fault_rd_q    <= 1'b0;
    end else begin
      case (state_q)
        MONITOR: begin
          if (hit) begin
            state_q       <= FAULT;
            irq_q         <= 1'b1;
            rst_req_q     <= 1'b1;
            fault_id_q    <= hit_id;
            fault_cause_q <= hit_cause;
            fault_rd_q    <= hit_rd;
          end
        end
        FAULT: begin
          if (rst_stat_i) begin
            state_q   <= RESET;
            rst_req_q <= 1'b0;
          end
        end
        RESET: begin
          if (!rst_stat_i) state_q <= CLEAR;
        end
        CLEAR: begin
          state_q       <= MONITOR;
          irq_q         <= 1'b0;
          fault_id_q    <= '0;
          fault_cause_q <= CAUSE_NONE;
          fault_rd_q    <= 1'b0;
        end
        default: state_q <= MONITOR;
      endcase
    end
  end

  assign irq_o         = irq_q;
  assign rst_req_o     = rst_req_q;
  assign fault_id_o    = fault_id_q;
  assign fault_cause_o = fault_cause_q;
  assign fault_rd_o    = fault_rd_q;
  assign aw_stall_o    = full_w[aw_id_i];
  assign ar_stall_o    = full_r[ar_id_i];

endmodule
